ofm_axi_writer: RTL and testbench

OFM_AXI_WRITER -- requirements
Module: ofm_axi_writer

---
 rtl/ofm_axi_writer_pkg.sv | 36 +++
 rtl/ofm_axi_writer_if.sv | 42 ++++
 rtl/ofm_wmst_burst_calc.sv | 83 ++++++++
 rtl/ofm_axi_writer.sv | 178 +++++++++++++++++
 tb/tb_ofm_axi_writer.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ofm_axi_writer_pkg.sv
// ----------------------------------------------------------------------------
// ofm_axi_writer_pkg
// Shared definitions for the output-feature-map AXI write master:
//   - wmst_state_e     : writer FSM state encoding
//   - AXI_BURST_INCR   : AXI4 INCR burst type
//   - AXI_RESP_OKAY    : AXI4 OKAY write response
//   - beat_size_log2() : log2 of the beat size in bytes (AXI awsize value)
// ----------------------------------------------------------------------------
package ofm_axi_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_DONE = 3'd4
    } wmst_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // DATA_WIDTH is a power of two >= 32, so the byte count is an exact power of two.
    function automatic int unsigned beat_size_log2(input int unsigned data_width);
        int unsigned bytes;
        int unsigned n;
        bytes = data_width / 8;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) == bytes) begin
                n = i;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/ofm_axi_writer_if.sv
// ----------------------------------------------------------------------------
// ofm_axi_writer_if
// AXI4 write channels (AW, W, B) used by the ofm writer.
//   master modport : drives aw*/w*/bready, samples awready/wready/bvalid/bresp
//   slave modport  : the interconnect side
// Parameters: ADDR_WIDTH (byte address bits), DATA_WIDTH (data bits).
// ----------------------------------------------------------------------------
interface ofm_axi_writer_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;

    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;

    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/ofm_wmst_burst_calc.sv
// ----------------------------------------------------------------------------
// ofm_wmst_burst_calc
// Burst sizing for the ofm writer. Holds the remaining beat count and the
// byte tail of the current transfer and derives the current burst length,
// awlen, the last-burst flag and the strobe for the transfer's final beat.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   load          : latch a new transfer from load_size (bytes)
//   load_size     : transfer length in bytes
//   load_zero     : load_size rounds to zero beats (combinational)
//   consume       : current burst retired (B handshake)
//   burst_len     : beats in the current burst = min(remaining, MAX_BURST)
//   awlen         : burst_len - 1
//   last_burst    : current burst is the final one of the transfer
//   final_strb    : byte strobe for the transfer's final beat
// ----------------------------------------------------------------------------
module ofm_wmst_burst_calc
    import ofm_axi_writer_pkg::*;
#(
    parameter  int DATA_WIDTH = 512,
    parameter  int MAX_BURST  = 64,
    localparam int BSHIFT     = beat_size_log2(DATA_WIDTH),
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [63:0]       load_size,
    output logic              load_zero,
    input  logic              consume,
    output logic [31:0]       burst_len,
    output logic [7:0]        awlen,
    output logic              last_burst,
    output logic [STRB_W-1:0] final_strb
);

    logic [31:0]       remaining_q, remaining_d;
    logic [BSHIFT-1:0] tail_q, tail_d;

    logic [BSHIFT-1:0] size_tail;
    logic [31:0]       size_beats;
    logic              unused_size_hi;

    // Beat counts are 32-bit; sizes beyond 2^32 beats are outside the supported range.
    assign size_tail      = load_size[BSHIFT-1:0];
    assign size_beats     = load_size[BSHIFT +: 32] + {31'd0, (size_tail != '0)};
    assign load_zero      = (size_beats == '0);
    assign unused_size_hi = ^load_size[63:BSHIFT+32];

    always_comb begin
        remaining_d = remaining_q;
        tail_d      = tail_q;
        if (load) begin
            remaining_d = size_beats;
            tail_d      = size_tail;
        end else if (consume) begin
            remaining_d = remaining_q - burst_len;
        end
    end

    always_comb begin
        burst_len  = (remaining_q > 32'(MAX_BURST)) ? 32'(MAX_BURST) : remaining_q;
        awlen      = 8'(burst_len - 32'd1);
        last_burst = (remaining_q <= 32'(MAX_BURST));
        final_strb = '1;
        if (tail_q != '0) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                final_strb[i] = (i < 32'(tail_q));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remaining_q <= '0;
            tail_q      <= '0;
        end else begin
            remaining_q <= remaining_d;
            tail_q      <= tail_d;
        end
    end

endmodule

// File: rtl/ofm_axi_writer.sv
// ----------------------------------------------------------------------------
// ofm_axi_writer
// Writes the output-feature-map stream to memory as AXI4 INCR bursts, one
// burst outstanding at a time. The stream is passed straight through to the
// W channel (wvalid = tvalid, tready = wready) with no buffering.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   wmst_req          : start pulse (accepted only when idle)
//   wmst_addr         : start byte address, beat-aligned
//   wmst_xfer_size    : transfer length in bytes
//   wmst_done         : one-cycle completion pulse
//   busy              : transfer in progress (accept through done)
//   tdata/tvalid/tready : ofm stream input
//   m_axi             : AXI4 write channels (master modport)
//   bresp_err         : sticky non-OKAY response flag (WMST_BRESP_CHK_EN only)
// Optional feature macro: WMST_BRESP_CHK_EN
// ----------------------------------------------------------------------------
module ofm_axi_writer
    import ofm_axi_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int MAX_BURST  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wmst_req,
    input  logic [ADDR_WIDTH-1:0] wmst_addr,
    input  logic [63:0]           wmst_xfer_size,
    output logic                  wmst_done,
    output logic                  busy,
    input  logic [DATA_WIDTH-1:0] tdata,
    input  logic                  tvalid,
    output logic                  tready,
    ofm_axi_writer_if.master      m_axi
`ifdef WMST_BRESP_CHK_EN
    ,
    output logic                  bresp_err
`endif
);

    localparam int BSHIFT = beat_size_log2(DATA_WIDTH);
    localparam int STRB_W = DATA_WIDTH / 8;

    wmst_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           beat_cnt_q, beat_cnt_d;

    logic              accept;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              wlast_c;

    logic              load_zero;
    logic [31:0]       burst_len;
    logic [7:0]        calc_awlen;
    logic              last_burst;
    logic [STRB_W-1:0] final_strb;

    ofm_wmst_burst_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) u_burst_calc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .load_size  (wmst_xfer_size),
        .load_zero  (load_zero),
        .consume    (b_hs),
        .burst_len  (burst_len),
        .awlen      (calc_awlen),
        .last_burst (last_burst),
        .final_strb (final_strb)
    );

    assign accept  = (state_q == ST_IDLE) && wmst_req;
    assign aw_hs   = (state_q == ST_AW) && m_axi.awready;
    assign w_hs    = (state_q == ST_W) && tvalid && m_axi.wready;
    assign b_hs    = (state_q == ST_B) && m_axi.bvalid;
    assign wlast_c = (state_q == ST_W) && (beat_cnt_q == (burst_len - 32'd1));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d     = wmst_addr;
                    beat_cnt_d = '0;
                    state_d    = load_zero ? ST_DONE : ST_AW;
                end
            end
            ST_AW: begin
                if (aw_hs) begin
                    beat_cnt_d = '0;
                    state_d    = ST_W;
                end
            end
            ST_W: begin
                if (w_hs) begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
                    if (wlast_c) begin
                        state_d = ST_B;
                    end
                end
            end
            ST_B: begin
                if (b_hs) begin
                    if (last_burst) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + (ADDR_WIDTH'(burst_len) << BSHIFT);
                        state_d = ST_AW;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // All AXI outputs decode the registered state, so they are quiet in reset.
    assign m_axi.awvalid = (state_q == ST_AW);
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = calc_awlen;
    assign m_axi.awsize  = 3'(BSHIFT);
    assign m_axi.awburst = AXI_BURST_INCR;
    assign m_axi.wvalid  = (state_q == ST_W) && tvalid;
    assign m_axi.wdata   = tdata;
    // Partial strobe only on the last beat of the last burst.
    assign m_axi.wstrb   = (wlast_c && last_burst) ? final_strb : '1;
    assign m_axi.wlast   = wlast_c;
    assign m_axi.bready  = (state_q == ST_B);
    assign tready        = (state_q == ST_W) && m_axi.wready;
    assign wmst_done     = (state_q == ST_DONE);
    assign busy          = (state_q != ST_IDLE);

`ifdef WMST_BRESP_CHK_EN
    logic bresp_err_q, bresp_err_d;

    always_comb begin
        bresp_err_d = bresp_err_q;
        if (accept) begin
            bresp_err_d = 1'b0;
        end else if (b_hs && (m_axi.bresp != AXI_RESP_OKAY)) begin
            bresp_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bresp_err_q <= 1'b0;
        end else begin
            bresp_err_q <= bresp_err_d;
        end
    end

    assign bresp_err = bresp_err_q;
`else
    logic unused_bresp;
    assign unused_bresp = ^m_axi.bresp;
`endif

endmodule

// File: tb/tb_ofm_axi_writer.sv
module tb_ofm_axi_writer;

    localparam int AW_W = 64;
    localparam int DW   = 512;
    localparam int MB   = 64;
    localparam int BPB  = DW / 8;

    typedef struct packed {
        logic [AW_W-1:0] addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
    } aw_t;

    typedef struct {
        logic [DW-1:0]  data;
        logic [BPB-1:0] strb;
        logic           last;
    } w_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            wmst_req;
    logic [AW_W-1:0] wmst_addr;
    logic [63:0]     wmst_xfer_size;
    logic            wmst_done;
    logic            busy;
    logic [DW-1:0]   tdata;
    logic            tvalid;
    logic            tready;
`ifdef WMST_BRESP_CHK_EN
    logic            bresp_err;
`endif

    ofm_axi_writer_if #(.ADDR_WIDTH(AW_W), .DATA_WIDTH(DW)) axi ();

    ofm_axi_writer #(
        .ADDR_WIDTH (AW_W),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wmst_req       (wmst_req),
        .wmst_addr      (wmst_addr),
        .wmst_xfer_size (wmst_xfer_size),
        .wmst_done      (wmst_done),
        .busy           (busy),
        .tdata          (tdata),
        .tvalid         (tvalid),
        .tready         (tready),
        .m_axi          (axi)
`ifdef WMST_BRESP_CHK_EN
        ,
        .bresp_err      (bresp_err)
`endif
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Shared environment state
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int v_pct = 100;
    int r_pct = 100;
    int err_burst = -1;
    logic [DW-1:0] src_mem[$];
    int src_idx = 0;
    aw_t aw_q[$];
    w_t  w_q[$];
    int b_pending = 0;
    int b_cnt = 0;
    int b_last_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int viol_aw_stable = 0;
    int viol_overlap = 0;
    int viol_pass = 0;

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    // Stream source: holds tvalid until accepted, random gaps otherwise
    initial begin
        bit fire;
        tvalid = 1'b0;
        tdata  = '0;
        forever begin
            @(negedge clk);
            fire = tvalid && tready;
            @(posedge clk); #1;
            if (!rst_n) begin
                tvalid = 1'b0;
            end else begin
                if (fire) src_idx++;
                if (!(tvalid && !fire))
                    tvalid = (src_idx < src_mem.size()) && ($urandom_range(99) < v_pct);
                tdata = (src_idx < src_mem.size()) ? src_mem[src_idx] : '0;
            end
        end
    end

    // AW slave
    initial begin
        aw_t prev;
        aw_t cur;
        bit  prev_stall;
        prev_stall = 0;
        axi.awready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
            end else if (axi.awvalid) begin
                cur = '{axi.awaddr, axi.awlen, axi.awsize, axi.awburst};
                if (prev_stall && cur != prev) viol_aw_stable++;
                if (b_pending != 0) viol_overlap++;
                if (axi.awready) begin
                    aw_q.push_back(cur);
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    prev = cur;
                end
            end else begin
                if (prev_stall) viol_aw_stable++;
                prev_stall = 0;
            end
            @(posedge clk); #1;
            axi.awready = rst_n && ($urandom_range(99) < r_pct);
        end
    end

    // W slave
    initial begin
        axi.wready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if ((tvalid && tready) != (axi.wvalid && axi.wready)) viol_pass++;
                if (axi.wvalid && axi.wready) begin
                    if (axi.wdata !== tdata) viol_pass++;
                    w_q.push_back('{axi.wdata, axi.wstrb, axi.wlast});
                    if (axi.wlast) b_pending++;
                end
                if (axi.bready && (axi.awvalid || axi.wvalid)) viol_overlap++;
            end
            @(posedge clk); #1;
            axi.wready = rst_n && ($urandom_range(99) < r_pct);
        end
    end

    // B slave
    initial begin
        bit hs;
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        forever begin
            @(negedge clk);
            hs = 0;
            if (!rst_n) begin
                b_pending = 0;
            end else if (axi.bvalid && axi.bready) begin
                b_pending--;
                b_cnt++;
                b_last_cyc = cyc;
                hs = 1;
            end
            @(posedge clk); #1;
            if (!rst_n || hs) begin
                axi.bvalid = 1'b0;
            end else if (!axi.bvalid && b_pending > 0 && $urandom_range(99) < r_pct) begin
                axi.bvalid = 1'b1;
                axi.bresp  = (b_cnt == err_burst) ? 2'b10 : 2'b00;
            end
        end
    end

    // Completion monitor
    initial forever begin
        @(negedge clk);
        if (rst_n && wmst_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic run_xfer(input string nm, input logic [63:0] addr, input logic [63:0] size,
                            input int vp, input int rp, input int eb, input bit dup_req);
        int nbeats, nbursts, req_cyc, waited, rem, len, g, bi;
        logic [63:0] a;
        logic [BPB-1:0] exp_strb;
        nbeats = int'((size + 64'(BPB - 1)) / 64'(BPB));
        src_idx = 0;
        src_mem.delete();
        for (int i = 0; i < nbeats; i++) src_mem.push_back(rand_beat());
        aw_q.delete();
        w_q.delete();
        done_cnt = 0; b_cnt = 0;
        viol_aw_stable = 0; viol_overlap = 0; viol_pass = 0;
        v_pct = vp; r_pct = rp; err_burst = eb;

        @(posedge clk); #2;
        wmst_addr = addr; wmst_xfer_size = size; wmst_req = 1'b1;
        req_cyc = cyc;
        @(posedge clk); #2;
        if (dup_req) begin
            wmst_addr = addr + 64'h10000; wmst_xfer_size = 64'd640; wmst_req = 1'b1;
        end else begin
            wmst_req = 1'b0;
        end
        @(negedge clk);
        check({nm, "_busy_accept"}, busy, 1);
        @(posedge clk); #2;
        wmst_req = 1'b0;

        waited = 0;
        while (done_cnt == 0 && waited < 6000) begin
            @(negedge clk);
            waited++;
        end
        check({nm, "_done_seen"}, (done_cnt > 0), 1);
        repeat (4) @(negedge clk);
        check({nm, "_done_once"}, done_cnt, 1);
        check({nm, "_idle_after"}, busy, 0);

        // Reference: split into bursts of at most MB beats
        a = addr; rem = nbeats; bi = 0; g = 0;
        while (rem > 0) begin
            len = (rem > MB) ? MB : rem;
            if (bi < aw_q.size()) begin
                check({nm, "_awaddr"}, aw_q[bi].addr, a);
                check({nm, "_awlen"}, aw_q[bi].len, len - 1);
                check({nm, "_awsize"}, aw_q[bi].size, 6);
                check({nm, "_awburst"}, aw_q[bi].burst, 1);
            end
            for (int j = 0; j < len; j++) begin
                if (g < w_q.size()) begin
                    exp_strb = '1;
                    if (g == nbeats - 1 && (size % 64'(BPB)) != 0)
                        exp_strb = (64'd1 << (size % 64'(BPB))) - 64'd1;
                    check({nm, "_wdata"}, w_q[g].data, src_mem[g]);
                    check({nm, "_wstrb"}, w_q[g].strb, exp_strb);
                    check({nm, "_wlast"}, w_q[g].last, (j == len - 1));
                end
                g++;
            end
            a = a + 64'(len * BPB);
            rem -= len;
            bi++;
        end
        nbursts = bi;
        check({nm, "_aw_count"}, aw_q.size(), nbursts);
        check({nm, "_beat_count"}, w_q.size(), nbeats);
        check({nm, "_b_count"}, b_cnt, nbursts);
        check({nm, "_src_consumed"}, src_idx, nbeats);
        check({nm, "_aw_stable"}, viol_aw_stable, 0);
        check({nm, "_overlap"}, viol_overlap, 0);
        check({nm, "_passthru"}, viol_pass, 0);
        if (nbeats == 0)
            check({nm, "_zero_span"}, done_cyc - req_cyc + 1, 2);
        else
            check({nm, "_done_after_b"}, done_cyc - b_last_cyc, 1);
`ifdef WMST_BRESP_CHK_EN
        check({nm, "_bresp_err"}, bresp_err, (eb >= 0 && eb < nbursts));
`endif
    endtask

    task automatic reset_mid();
        src_idx = 0;
        src_mem.delete();
        for (int i = 0; i < 64; i++) src_mem.push_back(rand_beat());
        done_cnt = 0; v_pct = 100; r_pct = 100; err_burst = -1;
        @(posedge clk); #2;
        wmst_addr = 64'h5000; wmst_xfer_size = 64'd4096; wmst_req = 1'b1;
        @(posedge clk); #2;
        wmst_req = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_busy", busy, 0);
        check("rstmid_awvalid", axi.awvalid, 0);
        check("rstmid_wvalid", axi.wvalid, 0);
        check("rstmid_wlast", axi.wlast, 0);
        check("rstmid_bready", axi.bready, 0);
        check("rstmid_tready", tready, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rstmid_no_done", done_cnt, 0);
        check("rstmid_idle", busy, 0);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rs;
        wmst_req = 1'b0; wmst_addr = '0; wmst_xfer_size = '0;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_done", wmst_done, 0);
        check("rst_busy", busy, 0);
        check("rst_awvalid", axi.awvalid, 0);
        check("rst_wvalid", axi.wvalid, 0);
        check("rst_wlast", axi.wlast, 0);
        check("rst_bready", axi.bready, 0);
        check("rst_tready", tready, 0);
        check("rst_awaddr", axi.awaddr, 0);
`ifdef WMST_BRESP_CHK_EN
        check("rst_bresp_err", bresp_err, 0);
`endif
        @(posedge clk); #2 rst_n = 1'b1;

        run_xfer("single", 64'h1000, 64'd4096, 100, 100, -1, 0);
        run_xfer("multi", 64'h0, 64'd8320, 100, 100, -1, 0);
        run_xfer("partial", 64'h40000, 64'd100, 100, 100, -1, 0);
        run_xfer("zero", 64'h8000, 64'd0, 100, 100, -1, 1);
        for (int t = 0; t < 5; t++) begin
            ra = 64'($urandom()) << 6;
            rs = 64'($urandom_range(1, 9000));
            run_xfer("rand", ra, rs, 50, 50, -1, (t == 2));
        end
        run_xfer("slverr", 64'h2000, 64'd8320, 70, 70, 1, 0);
        reset_mid();
        run_xfer("recover", 64'h3000, 64'd200, 60, 60, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
